// File: rtl/pipeline_controller_pkg.sv
// Shared types for the rv32i pipeline hazard/sequencing controller:
// FSM states, the stage control word and its canned values.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic bubble_if_id;
    logic bubble_id_ex;
  } pipe_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control words, bit order as in pipe_ctrl_t
  localparam pipe_ctrl_t CTRL_FREEZE     = 7'b0000000;
  localparam pipe_ctrl_t CTRL_FLUSH      = 7'b1111111;
  localparam pipe_ctrl_t CTRL_LOAD_USE   = 7'b0011101;
  localparam pipe_ctrl_t CTRL_FETCH_WAIT = 7'b0111110;
  localparam pipe_ctrl_t CTRL_ADVANCE    = 7'b1111100;

endpackage

// File: rtl/pipeline_controller_if.sv
// Handshake and stage-control signals between the pipeline controller
// (master) and the rv32i datapath (slave).
interface pipeline_controller_if;
  logic       imem_req;
  logic       imem_resp;
  logic       dmem_req;
  logic       dmem_resp;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_br_taken;
  logic       drain_req;
  logic       drained;
  logic       load_pc;
  logic       load_if_id;
  logic       load_id_ex;
  logic       load_ex_mem;
  logic       load_mem_wb;
  logic       bubble_if_id;
  logic       bubble_id_ex;

  modport master (
    input  imem_resp, dmem_req, dmem_resp, id_rs1, id_rs2, id_uses_rs1,
           id_uses_rs2, ex_rd, ex_is_load, ex_br_taken, drain_req,
    output imem_req, drained, load_pc, load_if_id, load_id_ex, load_ex_mem,
           load_mem_wb, bubble_if_id, bubble_id_ex
  );

  modport slave (
    output imem_resp, dmem_req, dmem_resp, id_rs1, id_rs2, id_uses_rs1,
           id_uses_rs2, ex_rd, ex_is_load, ex_br_taken, drain_req,
    input  imem_req, drained, load_pc, load_if_id, load_id_ex, load_ex_mem,
           load_mem_wb, bubble_if_id, bubble_id_ex
  );
endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard compare: the ID-stage instruction reads a register
// that the load sitting in EX has not yet written back.
module pipeline_controller_hazard_detect
  import pipeline_controller_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       load_use
);

  assign load_use = ex_is_load && (ex_rd != REG_ZERO) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the 5-stage rv32i pipeline: stage loads,
// bubbles, drain handshake, per-stage valid shadows and perf counters.
//
// state   | meaning
// RUN     | normal fetch and execute
// DRAIN   | no new fetches; finish outstanding fetch, let stages empty
// DRAINED | pipeline empty, fetch stopped, all stages frozen
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_controller_if.master pif,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  pipe_ctrl_state_t state_q, state_d;
  pipe_ctrl_t       ctrl;
  logic             v_ifid, v_idex, v_exmem, v_memwb, fetch_busy_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, mem_stall, fe_stall, imem_req, drained, flush, pipe_empty;

  pipeline_controller_hazard_detect u_hazard (
    .id_rs1      (pif.id_rs1),
    .id_rs2      (pif.id_rs2),
    .id_uses_rs1 (pif.id_uses_rs1),
    .id_uses_rs2 (pif.id_uses_rs2),
    .ex_rd       (pif.ex_rd),
    .ex_is_load  (pif.ex_is_load),
    .load_use    (load_use)
  );

  assign mem_stall  = pif.dmem_req & ~pif.dmem_resp;
  assign pipe_empty = ~(v_ifid | v_idex | v_exmem | v_memwb) & ~fetch_busy_q;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    drained  = 1'b0;
    fe_stall = 1'b0;
    flush    = 1'b0;
    ctrl     = CTRL_FREEZE;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          imem_req = 1'b1;
          if (pif.drain_req) state_d = DRAIN;
        end
        DRAIN: begin
          imem_req = fetch_busy_q;
          if (!pif.drain_req) state_d = RUN;
          else if (pipe_empty && !mem_stall) state_d = DRAINED;
        end
        DRAINED: begin
          drained = 1'b1;
          if (!pif.drain_req) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
      fe_stall = imem_req & ~pif.imem_resp;
      if (state_q != DRAINED) begin
        // A redirect waits out an in-flight fetch so the fetch address stays stable
        if (mem_stall || (pif.ex_br_taken && fe_stall)) begin
          ctrl = CTRL_FREEZE;
        end else if (pif.ex_br_taken) begin
          ctrl  = CTRL_FLUSH;
          flush = 1'b1;
        end else if (load_use) begin
          ctrl = CTRL_LOAD_USE;
        end else if (fe_stall || state_q == DRAIN) begin
          ctrl = CTRL_FETCH_WAIT;
        end else begin
          ctrl = CTRL_ADVANCE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      v_ifid       <= 1'b0;
      v_idex       <= 1'b0;
      v_exmem      <= 1'b0;
      v_memwb      <= 1'b0;
      fetch_busy_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_busy_q <= imem_req & ~pif.imem_resp;
      if (ctrl.load_if_id)  v_ifid  <= ~ctrl.bubble_if_id & pif.imem_resp;
      if (ctrl.load_id_ex)  v_idex  <= ~ctrl.bubble_id_ex & v_ifid;
      if (ctrl.load_ex_mem) v_exmem <= v_idex;
      if (ctrl.load_mem_wb) v_memwb <= v_exmem;
      if (!ctrl.load_pc && state_q != DRAINED) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign pif.imem_req     = imem_req;
  assign pif.drained      = drained;
  assign pif.load_pc      = ctrl.load_pc;
  assign pif.load_if_id   = ctrl.load_if_id;
  assign pif.load_id_ex   = ctrl.load_id_ex;
  assign pif.load_ex_mem  = ctrl.load_ex_mem;
  assign pif.load_mem_wb  = ctrl.load_mem_wb;
  assign pif.bubble_if_id = ctrl.bubble_if_id;
  assign pif.bubble_id_ex = ctrl.bubble_id_ex;
  assign stall_cnt        = rst ? '0 : stall_cnt_q;
  assign flush_cnt        = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus a
// randomized phase, checked every cycle against a stage-occupancy model.
module tb_pipeline_controller;
  localparam int CNT_W = 6;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;
  localparam int A_FREEZE = 0, A_FLUSH = 1, A_LU = 2, A_FWAIT = 3, A_ADV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_controller_if pif ();

  pipeline_controller #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pif       (pif),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: occupancy of IF/ID, ID/EX, EX/MEM, MEM/WB as bits 0..3
  int               m_mode = M_RUN;
  bit [3:0]         occ = '0;
  bit               m_fbusy = 1'b0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
  int               act;
  bit               e_req, e_mst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] act_ctrl(input int a);
    case (a)
      A_FLUSH: return 7'b1111111;
      A_LU:    return 7'b0011101;
      A_FWAIT: return 7'b0111110;
      A_ADV:   return 7'b1111100;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {pif.load_pc, pif.load_if_id, pif.load_id_ex, pif.load_ex_mem,
            pif.load_mem_wb, pif.bubble_if_id, pif.bubble_id_ex};
  endfunction

  task automatic sample();
    bit fst, lu;
    @(negedge clk);
    act   = A_FREEZE;
    e_req = 1'b0;
    e_mst = pif.dmem_req && !pif.dmem_resp;
    if (!rst) begin
      e_req = (m_mode == M_RUN) || (m_mode == M_DRAIN && m_fbusy);
      fst   = e_req && !pif.imem_resp;
      lu    = pif.ex_is_load && pif.ex_rd != 5'd0 &&
              ((pif.id_uses_rs1 && pif.id_rs1 == pif.ex_rd) ||
               (pif.id_uses_rs2 && pif.id_rs2 == pif.ex_rd));
      if (m_mode != M_DRAINED) begin
        if (e_mst || (pif.ex_br_taken && fst)) act = A_FREEZE;
        else if (pif.ex_br_taken)              act = A_FLUSH;
        else if (lu)                           act = A_LU;
        else if (fst || m_mode == M_DRAIN)     act = A_FWAIT;
        else                                   act = A_ADV;
      end
    end
    chk("ctrl", 32'(dut_ctrl()), 32'(act_ctrl(act)));
    chk("imem_req", 32'(pif.imem_req), 32'(e_req));
    chk("drained", 32'(pif.drained), 32'(!rst && m_mode == M_DRAINED));
    chk("stall_cnt", 32'(stall_cnt), rst ? 32'd0 : 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), rst ? 32'd0 : 32'(m_flush));
  endtask

  task automatic advance();
    bit src, empty;
    @(posedge clk);
    if (rst) begin
      m_mode = M_RUN; occ = '0; m_fbusy = 1'b0; m_stall = '0; m_flush = '0;
    end else begin
      src   = (m_mode == M_RUN) && pif.imem_resp;
      empty = (occ == 4'd0) && !m_fbusy && !e_mst;
      if (m_mode != M_DRAINED && act != A_FLUSH && act != A_ADV) m_stall = m_stall + 1'b1;
      if (act == A_FLUSH) m_flush = m_flush + 1'b1;
      case (act)
        A_FLUSH: occ = {occ[2:1], 2'b00};
        A_LU:    occ = {occ[2:1], 1'b0, occ[0]};
        A_FWAIT: occ = {occ[2:0], 1'b0};
        A_ADV:   occ = {occ[2:0], src};
        default: ;
      endcase
      case (m_mode)
        M_RUN:   if (pif.drain_req) m_mode = M_DRAIN;
        M_DRAIN: if (!pif.drain_req) m_mode = M_RUN; else if (empty) m_mode = M_DRAINED;
        default: if (!pif.drain_req) m_mode = M_RUN;
      endcase
      m_fbusy = e_req && !pif.imem_resp;
    end
    #1;
  endtask

  task automatic set_idle();
    pif.imem_resp = 1'b1;  pif.dmem_req = 1'b0;    pif.dmem_resp = 1'b0;
    pif.id_rs1 = 5'd1;     pif.id_rs2 = 5'd2;      pif.id_uses_rs1 = 1'b0;
    pif.id_uses_rs2 = 1'b0; pif.ex_rd = 5'd3;      pif.ex_is_load = 1'b0;
    pif.ex_br_taken = 1'b0; pif.drain_req = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    pif.ex_is_load = 1'b1; pif.ex_rd = rd; pif.id_rs1 = 5'd5; pif.id_uses_rs1 = 1'b1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  logic [CNT_W-1:0] s0;
  bit               seen;

  initial begin
    set_idle();
    // Reset
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    // Load-use with rd=5, then the same compare against x0
    set_load_use(5'd5);
    sample(); chk("lu_bubble", 32'(dut_ctrl()), 32'h1D); advance();
    set_idle();
    sample(); chk("lu_resume", 32'(dut_ctrl()), 32'h7C); advance();
    set_load_use(5'd0);
    sample(); chk("lu_x0", 32'(dut_ctrl()), 32'h7C); advance();
    set_idle();

    // Data memory miss for 4 cycles
    pif.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 0) s0 = stall_cnt;
      chk("dmiss_freeze", 32'(dut_ctrl()), 32'h0);
      advance();
    end
    pif.dmem_resp = 1'b1;
    sample();
    chk("dmiss_stall4", 32'(stall_cnt), 32'(CNT_W'(s0 + CNT_W'(4))));
    chk("dmiss_resume", 32'(dut_ctrl()), 32'h7C);
    advance();
    set_idle();

    // Taken branch behind an outstanding fetch
    pif.ex_br_taken = 1'b1; pif.imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("br_wait_freeze", 32'(dut_ctrl()), 32'h0); advance();
    end
    pif.imem_resp = 1'b1;
    sample(); chk("br_flush", 32'(dut_ctrl()), 32'h7F); advance();
    set_idle();
    sample(); chk("flush_cnt1", 32'(flush_cnt), 32'd1); advance();

    // Branch and load-use together: flush wins, no extra bubble after
    pif.ex_br_taken = 1'b1; set_load_use(5'd5);
    sample(); chk("br_lu_flush", 32'(dut_ctrl()), 32'h7F); advance();
    set_idle();
    sample(); chk("br_lu_after", 32'(dut_ctrl()), 32'h7C); chk("flush_cnt2", 32'(flush_cnt), 32'd2); advance();

    // Drain with a pending fetch
    for (int i = 0; i < 4; i++) cyc();
    pif.drain_req = 1'b1; pif.imem_resp = 1'b0;
    cyc();
    sample(); chk("drain_pending_req", 32'(pif.imem_req), 32'd1); advance();
    pif.imem_resp = 1'b1;
    sample(); chk("drain_resp_discard", 32'(dut_ctrl()), 32'h3E); advance();
    pif.imem_resp = 1'b0;
    sample(); chk("drain_no_fetch", 32'(pif.imem_req), 32'd0); advance();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      sample();
      if (pif.drained) seen = 1'b1;
      advance();
    end
    chk("drain_reached", 32'(seen), 32'd1);
    sample(); s0 = stall_cnt; advance();
    for (int i = 0; i < 3; i++) cyc();
    sample(); chk("drained_no_stall_cnt", 32'(stall_cnt), 32'(s0)); advance();
    pif.drain_req = 1'b0; pif.imem_resp = 1'b1;
    sample(); chk("undrain_req_low", 32'(pif.imem_req), 32'd0); advance();
    sample(); chk("undrain_req_high", 32'(pif.imem_req), 32'd1); advance();

    // Reset in DRAIN with a fetch outstanding, stale response during reset
    for (int i = 0; i < 4; i++) cyc();
    pif.drain_req = 1'b1; pif.imem_resp = 1'b0;
    cyc();
    rst = 1'b1; pif.imem_resp = 1'b1;
    sample(); chk("rst_req", 32'(pif.imem_req), 32'd0); advance();
    rst = 1'b0; pif.imem_resp = 1'b0;
    sample();
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_run", 32'(pif.imem_req), 32'd1);
    advance();
    pif.imem_resp = 1'b1;
    cyc(); cyc();
    sample(); chk("rst_drain_empty", 32'(pif.drained), 32'd1); advance();
    set_idle();

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      pif.imem_resp   = ($urandom_range(3) != 0);
      pif.dmem_req    = ($urandom_range(2) == 0);
      pif.dmem_resp   = $urandom_range(1);
      pif.ex_br_taken = ($urandom_range(5) == 0);
      pif.ex_is_load  = ($urandom_range(2) == 0);
      pif.ex_rd       = 5'($urandom_range(7));
      pif.id_rs1      = 5'($urandom_range(7));
      pif.id_rs2      = 5'($urandom_range(7));
      pif.id_uses_rs1 = $urandom_range(1);
      pif.id_uses_rs2 = $urandom_range(1);
      if ($urandom_range(19) == 0) pif.drain_req = ~pif.drain_req;
      rst = ($urandom_range(99) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central hazard/sequencing controller for the 5-stage rv32i pipeline. It drives load enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- It also drives bubble selects. Each bubble select muxes an all-zero control word into the stage input.
- It resolves memory stalls, load-use hazards, taken-branch flushes and a drain/quiesce handshake.
- It keeps valid shadow bits per stage and performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_req_o  out  1  instruction fetch request
- imem_resp_i  in  1  fetch data valid this cycle
- dmem_req_i  in  1  MEM-stage instruction has a memory access in flight
- dmem_resp_i  in  1  data memory response this cycle
- id_rs1_i  in  5  IF/ID source register 1
- id_rs2_i  in  5  IF/ID source register 2
- id_uses_rs1_i  in  1  decoded instruction reads rs1
- id_uses_rs2_i  in  1  decoded instruction reads rs2
- ex_rd_i  in  5  ID/EX destination register
- ex_is_load_i  in  1  ID/EX holds a load
- ex_br_taken_i  in  1  EX resolves a taken branch/jump; PC mux selects target
- drain_req_i  in  1  request to empty the pipeline (fence.i/halt)
- drained_o  out  1  pipeline empty, fetch stopped
- load_pc_o  out  1  PC load
- load_if_id_o  out  1  IF/ID load
- load_id_ex_o  out  1  ID/EX load
- load_ex_mem_o  out  1  EX/MEM load
- load_mem_wb_o  out  1  MEM/WB load
- bubble_if_id_o  out  1  IF/ID input = zero word
- bubble_id_ex_o  out  1  ID/EX input = zero word
- stall_cnt_o  out  CNT_W  cycles with load_pc_o=0 outside DRAINED
- flush_cnt_o  out  CNT_W  taken-branch flushes performed

Behaviour:
- While rst is high, all outputs are 0. On reset, FSM=RUN, valid bits v_ifid/v_idex/v_exmem/v_memwb=0, fetch_busy_q=0, counters=0.
- Outputs are combinational from state and inputs. Decisions take effect at the same clock edge; there is no added latency.
- Derived terms:
  - mem_stall = dmem_req_i & ~dmem_resp_i
  - fe_stall = imem_req_o & ~imem_resp_i
  - load_use = ex_is_load_i & ex_rd_i!=0 & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i))
- Priority, highest first:
  1. mem_stall: all loads 0; bubbles 0.
  2. ex_br_taken_i & fe_stall: full freeze as in 1. The redirect waits for the in-flight fetch so the fetch address stays stable.
  3. ex_br_taken_i: load_pc=1; IF/ID and ID/EX loaded with bubble; EX/MEM and MEM/WB load; flush_cnt increments. If imem_resp_i is high this cycle, that fetch data is discarded via the IF/ID bubble.
  4. load_use: PC=0, IF/ID=0; ID/EX loaded with bubble; EX/MEM and MEM/WB load. This gives exactly one bubble per hazard.
  5. fe_stall: PC=0; IF/ID loaded with bubble; downstream stages advance.
  6. Otherwise, all loads 1 and no bubbles.
- imem_req_o is 1 in RUN. fetch_busy_q = imem_req_o & ~imem_resp_i, registered.
- Valid bits mirror the stage registers:
  - On load, a stage's bit takes the upstream bit, or 0 if bubbled.
  - IF/ID source valid = imem_resp_i.
  - MEM/WB is cleared when loaded with an invalid EX/MEM.
- FSM:
  - RUN -> DRAIN on drain_req_i.
  - DRAIN: imem_req_o = fetch_busy_q only. An outstanding fetch completes, and its response is discarded (IF/ID bubble, PC held). No new fetch is issued. Stages advance per the priority rules with the IF/ID input bubbled. A taken branch in DRAIN still loads the PC target.
  - DRAIN -> DRAINED when all valid bits are 0, fetch_busy_q=0 and mem_stall=0.
  - DRAINED: drained_o=1, all loads 0, imem_req_o=0.
  - DRAINED -> RUN when drain_req_i=0. The first fetch is issued in the following cycle.
- drain_req_i dropped during DRAIN: return to RUN on the next edge. Pipeline contents are preserved.
- Counters wrap at 2^CNT_W. stall_cnt does not count cycles in DRAINED.
- rst mid-operation (any state, outstanding fetch) returns to reset values on the next edge. A stale imem_resp_i arriving after reset is ignored because imem_req_o=0 during rst.

Decomposition:
- Shared rv32i_types package holds:
  - pipe_ctrl_state_t enum {RUN, DRAIN, DRAINED}
  - a pipe_ctrl_t struct bundling the five loads and two bubbles
  - a REG_ZERO constant
- Natural sub-module: hazard_detect, the combinational load_use compare. The FSM, valid tracking and counters stay in pipeline_controller.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, uses_rs1=1 -> one cycle of load_pc=0, load_if_id=0, bubble_id_ex=1, then all loads 1. Same stimulus with ex_rd=0 -> no stall.
- dmem miss: dmem_req=1, resp low for 4 cycles -> all loads 0 for 4 cycles; stall_cnt +4; resume on dmem_resp=1.
- Branch during outstanding fetch: imem_resp low 3 cycles with ex_br_taken=1 -> freeze 3 cycles. On resp: load_pc=1, bubble_if_id=1, bubble_id_ex=1; flush_cnt=1.
- Branch and load_use in the same cycle -> branch flush wins; no extra bubble cycle follows.
- Drain: 4 valid instructions in flight, drain_req=1 -> imem_req drops after the pending resp; drained_o=1 after 4 advancing cycles; drain_req=0 -> RUN and imem_req=1 one cycle later.
- Reset during DRAIN with fetch_busy=1 -> next cycle state RUN, counters 0, valid bits 0, and a late imem_resp_i does not set v_ifid.
